// File: rtl/dual_clock_gen_pkg.sv
// Shared types and defaults for the dual divided-clock generator.
package dual_clock_gen_pkg;
   localparam int CNT_W_DEF  = 16;
   localparam int EDGE_W_DEF = 32;

   typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_e;
   typedef enum logic [1:0] {DELAY, LOW, HIGH, PARKED} ch_phase_e;
endpackage

// File: rtl/dual_clock_gen_if.sv
// Command/status bundle between a controller and dual_clock_gen.
interface dual_clock_gen_if
   import dual_clock_gen_pkg::*;
#(
   parameter int CNT_W  = CNT_W_DEF,
   parameter int EDGE_W = EDGE_W_DEF
);
   logic              start;
   logic              stop;
   logic [CNT_W-1:0]  half1;
   logic [CNT_W-1:0]  half2;
   logic [CNT_W-1:0]  phase2;
   logic              running;
   logic              clk1_out;
   logic              clk2_out;
   logic [EDGE_W-1:0] count1;
   logic [EDGE_W-1:0] count2;
   logic              done;

   modport master (
      output start, stop, half1, half2, phase2,
      input  running, clk1_out, clk2_out, count1, count2, done
   );

   modport slave (
      input  start, stop, half1, half2, phase2,
      output running, clk1_out, clk2_out, count1, count2, done
   );
endinterface

// File: rtl/dual_clock_gen_clk_div_channel.sv
// One divided-clock channel: optional start delay, 50% divider, glitch-free
// park-low on stop, and a rising-edge counter.
module clk_div_channel
   import dual_clock_gen_pkg::*;
#(
   parameter int CNT_W  = CNT_W_DEF,
   parameter int EDGE_W = EDGE_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   input  logic              i_stop,
   input  logic [CNT_W-1:0]  i_half,
   input  logic [CNT_W-1:0]  i_phase,
   output logic              o_clk,
   output logic [EDGE_W-1:0] o_count,
   output logic              o_parked
);
   localparam logic [CNT_W-1:0]  ONE  = CNT_W'(1);
   localparam logic [EDGE_W-1:0] EONE = EDGE_W'(1);

   ch_phase_e         r_phase;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_out;
   logic [EDGE_W-1:0] r_count;

   // r_cnt holds the number of cycles already spent in the current phase,
   // so a phase ends on the edge where it equals the programmed length.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_phase <= PARKED;
         r_cnt   <= '0;
         r_out   <= 1'b0;
         r_count <= '0;
      end else if (i_start) begin
         r_phase <= (i_phase == '0) ? LOW : DELAY;
         r_cnt   <= ONE;
         r_out   <= 1'b0;
         r_count <= '0;
      end else begin
         case (r_phase)
            DELAY: begin
               if (i_stop)                r_phase <= PARKED;
               else if (r_cnt == i_phase) begin
                  r_phase <= LOW;
                  r_cnt   <= ONE;
               end else                   r_cnt <= r_cnt + ONE;
            end
            LOW: begin
               // a low output parks at once, even if a rise was due now
               if (i_stop)               r_phase <= PARKED;
               else if (r_cnt == i_half) begin
                  r_phase <= HIGH;
                  r_out   <= 1'b1;
                  r_cnt   <= ONE;
                  r_count <= r_count + EONE;
               end else                  r_cnt <= r_cnt + ONE;
            end
            HIGH: begin
               if (r_cnt == i_half) begin
                  r_phase <= i_stop ? PARKED : LOW;
                  r_out   <= 1'b0;
                  r_cnt   <= ONE;
               end else begin
                  r_cnt   <= r_cnt + ONE;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_clk    = r_out;
   assign o_count  = r_count;
   assign o_parked = (r_phase == PARKED);
endmodule

// File: rtl/dual_clock_gen.sv
// Two programmable divided clocks with start delay on channel 2, edge
// counters, and a start/stop FSM that parks both outputs low.
module dual_clock_gen
   import dual_clock_gen_pkg::*;
#(
   parameter int CNT_W  = CNT_W_DEF,
   parameter int EDGE_W = EDGE_W_DEF
) (
   input  logic            clk,
   input  logic            rst,
   dual_clock_gen_if.slave bus
);
   localparam int               NUM_CH = 2;
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

   state_e           r_state;
   state_e           w_next;
   logic             r_running;
   logic             r_done;
   logic             w_done_nxt;
   logic             w_start_take;
   logic             w_stop_take;
   logic             w_ch_stop;
   logic [CNT_W-1:0] r_half1;
   logic [CNT_W-1:0] r_half2;
   logic [CNT_W-1:0] r_phase2;

   logic [NUM_CH-1:0][CNT_W-1:0]  w_half;
   logic [NUM_CH-1:0][CNT_W-1:0]  w_phase;
   logic [NUM_CH-1:0]             w_clk;
   logic [NUM_CH-1:0]             w_parked;
   logic [NUM_CH-1:0][EDGE_W-1:0] w_count;

   always_comb begin
      w_next       = r_state;
      w_done_nxt   = 1'b0;
      w_start_take = 1'b0;
      w_stop_take  = 1'b0;
      case (r_state)
         IDLE: if (bus.start) begin
            w_next       = RUN;
            w_start_take = 1'b1;
         end
         RUN: if (bus.stop) begin
            w_next      = STOPPING;
            w_stop_take = 1'b1;
         end
         STOPPING: if (&w_parked) begin
            w_next     = IDLE;
            w_done_nxt = 1'b1;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_running <= 1'b0;
         r_done    <= 1'b0;
         r_half1   <= '0;
         r_half2   <= '0;
         r_phase2  <= '0;
      end else begin
         r_state   <= w_next;
         r_running <= (w_next != IDLE);
         r_done    <= w_done_nxt;
         if (w_start_take) begin
            // a zero half-period would stall the divider; run it as 1
            r_half1  <= (bus.half1 == '0) ? ONE : bus.half1;
            r_half2  <= (bus.half2 == '0) ? ONE : bus.half2;
            r_phase2 <= bus.phase2;
         end
      end
   end

   // Channels decide DELAY vs LOW at the start edge from the raw phase,
   // before the latched copy is visible.
   assign w_ch_stop  = w_stop_take | (r_state == STOPPING);
   assign w_half[0]  = r_half1;
   assign w_half[1]  = r_half2;
   assign w_phase[0] = '0;
   assign w_phase[1] = w_start_take ? bus.phase2 : r_phase2;

   generate
      for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
         clk_div_channel #(.CNT_W(CNT_W), .EDGE_W(EDGE_W)) u_ch (
            .clk      (clk),
            .rst      (rst),
            .i_start  (w_start_take),
            .i_stop   (w_ch_stop),
            .i_half   (w_half[g]),
            .i_phase  (w_phase[g]),
            .o_clk    (w_clk[g]),
            .o_count  (w_count[g]),
            .o_parked (w_parked[g])
         );
      end
   endgenerate

   assign bus.running  = r_running;
   assign bus.done     = r_done;
   assign bus.clk1_out = w_clk[0];
   assign bus.clk2_out = w_clk[1];
   assign bus.count1   = w_count[0];
   assign bus.count2   = w_count[1];
endmodule

// File: tb/tb_dual_clock_gen.sv
// Directed and randomized scenarios against a closed-form waveform model.
module tb_dual_clock_gen;
   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   dual_clock_gen_if bus ();
   dual_clock_gen dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Free-running waveform k edges after start: low through p, then period 2e.
   function automatic int ch_out(int k, int e, int p);
      if (k <= p) return 0;
      return ((k - p) / e) % 2;
   endfunction

   function automatic int ch_cnt(int k, int e, int p);
      if (k <= p) return 0;
      return ((k - p) / e + 1) / 2;
   endfunction

   task automatic check_all(input string tag, input int o1, input int o2, input int c1,
                            input int c2, input int run, input int dn);
      chk({tag, " clk1"},    bus.clk1_out, o1);
      chk({tag, " clk2"},    bus.clk2_out, o2);
      chk({tag, " count1"},  bus.count1,   c1);
      chk({tag, " count2"},  bus.count2,   c2);
      chk({tag, " running"}, bus.running,  run);
      chk({tag, " done"},    bus.done,     dn);
   endtask

   // One start..stop scenario. ks = stop edge index after start,
   // kr = reset edge index (0 = none), sas = stop pulsed with start.
   task automatic run(input int h1, input int h2, input int p2, input int ks,
                      input int kr, input bit sas);
      int e1, e2, kf1, kf2, kd, kend, o1, o2, c1, c2;
      bit hi1, hi2;
      string tag;
      e1  = (h1 == 0) ? 1 : h1;
      e2  = (h2 == 0) ? 1 : h2;
      hi1 = ch_out(ks - 1, e1, 0) == 1;
      hi2 = ch_out(ks - 1, e2, p2) == 1;
      kf1 = hi1 ? ((ks - 1) / e1 + 1) * e1 : ks;
      kf2 = hi2 ? p2 + ((ks - 1 - p2) / e2 + 1) * e2 : ks;
      kd  = ((kf1 > kf2) ? kf1 : kf2) + 1;
      kend = (kr > 0) ? kr : kd + 2;

      bus.start = 1'b1; bus.stop = sas;
      bus.half1 = 16'(h1); bus.half2 = 16'(h2); bus.phase2 = 16'(p2);
      @(posedge clk); #1;
      bus.start = 1'b0; bus.stop = 1'b0;
      bus.half1 = 16'($urandom_range(0, 9));
      bus.half2 = 16'($urandom_range(0, 9));
      bus.phase2 = 16'($urandom_range(0, 9));

      for (int k = 0; k <= kend; k++) begin
         tag = $sformatf("h=%0d/%0d p=%0d ks=%0d k=%0d", h1, h2, p2, ks, k);
         if (kr > 0 && k == kr) begin
            check_all({tag, " rst"}, 0, 0, 0, 0, 0, 0);
            rst = 1'b0;
            @(posedge clk); #1;
            check_all({tag, " post-rst"}, 0, 0, 0, 0, 0, 0);
            break;
         end
         if (k < ks) begin
            o1 = ch_out(k, e1, 0);  c1 = ch_cnt(k, e1, 0);
            o2 = ch_out(k, e2, p2); c2 = ch_cnt(k, e2, p2);
         end else begin
            o1 = (hi1 && k < kf1) ? 1 : 0; c1 = ch_cnt(ks - 1, e1, 0);
            o2 = (hi2 && k < kf2) ? 1 : 0; c2 = ch_cnt(ks - 1, e2, p2);
         end
         check_all(tag, o1, o2, c1, c2, (k < kd) ? 1 : 0, (k == kd) ? 1 : 0);
         // start in RUN and during STOPPING must both be ignored
         bus.stop  = (k + 1 == ks);
         bus.start = (k + 1 == ks + 1) || (ks >= 2 && k + 1 == ks - 1);
         rst       = (kr > 0 && k + 1 == kr);
         @(posedge clk); #1;
      end
      bus.start = 1'b0; bus.stop = 1'b0; rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      bus.start = 1'b0; bus.stop = 1'b0;
      bus.half1 = '0; bus.half2 = '0; bus.phase2 = '0;
      repeat (2) @(posedge clk);
      #1;
      check_all("reset", 0, 0, 0, 0, 0, 0);
      rst = 1'b0;

      run(2, 3, 0, 11, 0, 1'b0);
      run(1, 1, 5, 9, 0, 1'b0);
      run(4, 2, 1, 5, 0, 1'b0);
      run(5, 5, 20, 3, 0, 1'b0);
      run(3, 2, 4, 1000, 6, 1'b0);
      run(2, 3, 0, 11, 0, 1'b0);
      run(0, 1, 0, 6, 0, 1'b1);
      run(3, 0, 2, 7, 0, 1'b0);
      repeat (14) begin
         run(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
             int'($urandom_range(0, 12)), int'($urandom_range(1, 25)), 0,
             1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/dual_clock_gen.md
Name: dual_clock_gen

Overview:
Single-clock generator that drives the two divided clocks a dual-clock counting DUT consumes. Produces clk1_out and clk2_out with independent programmable half-periods and a start delay on clk2. Also keeps rising-edge counters for each output, so the bench can check DUT counts against generated counts. Start and stop are pulse commands; stopping is glitch-free, and each output always parks low.

Parameters:
CNT_W, 16, width of the half-period and phase-delay fields
EDGE_W, 32, width of the rising-edge counters

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins generation, sampled only in IDLE
stop  input  1  one-cycle pulse; requests glitch-free stop, sampled only in RUN
half1  input  CNT_W  clk1_out half-period in clk cycles, latched at start
half2  input  CNT_W  clk2_out half-period in clk cycles, latched at start
phase2  input  CNT_W  clk cycles clk2_out is held low before it starts dividing, latched at start
running  output  1  high in RUN and STOPPING
clk1_out  output  1  generated clock 1 (registered)
clk2_out  output  1  generated clock 2 (registered)
count1  output  EDGE_W  rising edges produced on clk1_out since last start
count2  output  EDGE_W  rising edges produced on clk2_out since last start
done  output  1  one-cycle pulse on STOPPING->IDLE

Behaviour:
- Reset (sync, active-high): state IDLE; running, clk1_out, clk2_out, done = 0; count1, count2 = 0; latched fields = 0. Reset asserted mid-RUN/STOPPING forces all outputs to these values at the next edge, with no done pulse.
- FSM: IDLE -> RUN on start. RUN -> STOPPING on stop. STOPPING -> IDLE when both outputs are low and parked. All other inputs are ignored in each state.
- Start edge E0:
  - half1, half2 and phase2 are latched. A half value of 0 is treated as 1.
  - count1 and count2 are cleared to 0. Both outputs are 0. running = 1 from E0.
- Channel 1:
  - clk1_out toggles every half1 cycles, so the first rise is at edge E0+half1.
  - Period is 2*half1 with a 50% duty cycle.
- Channel 2:
  - Held low through edge E0+phase2.
  - Then divides like channel 1, so the first rise is at E0+phase2+half2.
  - phase2 = 0 means no delay.
- Edge counters:
  - countN increments on the same edge where clkN_out goes 0->1.
  - Counters wrap modulo 2^EDGE_W with no saturation.
  - Counters hold their value in IDLE until the next start.
- Stop handling (stop sampled at edge Es):
  - An output that is high completes its current high phase, falls on schedule, then parks low.
  - An output that is low parks immediately and produces no further rising edge.
  - If channel 2 is still in its phase delay, it parks without ever rising.
- Leaving STOPPING: at the first edge where both channels are parked, the state goes to IDLE, running = 0 and done = 1 for exactly one cycle.
  - If both outputs are low at Es, IDLE and done occur at Es+1.
- Simultaneous inputs:
  - start and stop in the same cycle in IDLE: start is taken, stop is ignored.
  - start and stop in the same cycle in RUN: stop is taken, start is ignored.
  - start during STOPPING is ignored.
- Input changes: changes to half1, half2 or phase2 while running have no effect until the next start.
- Outputs are driven straight from flops, with no combinational path from inputs to outputs.

Decomposition:
- Package dual_clock_gen_pkg:
  - state enum {IDLE, RUN, STOPPING}
  - default CNT_W and EDGE_W localparams
  - channel phase enum {DELAY, LOW, HIGH, PARKED}
- Sub-module clk_div_channel (instantiated twice): one divider with its own phase-delay counter, half-period counter, stop-to-park logic, edge counter and a parked flag.
- Top level holds the FSM, the latching of the input fields and done generation. Channel 1 is instantiated with phase tied to 0.

Test Plan:
- half1=2, half2=3, phase2=0, start at E0 -> clk1_out rises at E2, E6, E10; clk2_out rises at E3, E9; at E10 count1=3, count2=2.
- half1=1, half2=1, phase2=5 -> clk2_out stays 0 through E5, first rise at E6; clk1_out rises at E1, E3, E5.
- half1=4 running, stop when clk1_out has been high for 1 cycle -> clk1_out stays high 3 more cycles, falls, never rises again; done is a single pulse; running=0 in the same cycle as done.
- half1=5, half2=5, phase2=20, stop at E3 (both low, clk2 in delay) -> IDLE and done at E4; count1=0, count2=0; no glitch on either output.
- Mid-RUN rst=1 for one cycle -> next edge: outputs 0, counts 0, running 0, no done; a subsequent start behaves as from E0.
- half1=0 -> behaves as half1=1 (clk1_out toggles every cycle); start+stop in the same cycle while in IDLE -> RUN entered, generation proceeds.
